// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte/message-index widths, default message length,
// and the PRGA state encoding. Also used by the key-scheduling block.
package rc4_pkg;

    localparam int unsigned BYTE_W      = 8;   // S-array entries, i, j, data bytes
    localparam int unsigned ADDR_W      = 5;   // message byte index k
    localparam int unsigned RC4_MSG_LEN = 32;  // default bytes per run
    localparam int unsigned BYTE_CYCLES = 12;  // clock cycles spent per message byte

    // One pass through SET_I..WR_D handles one message byte.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SET_I  = 4'd1,
        WAIT_I = 4'd2,
        GET_I  = 4'd3,
        SET_J  = 4'd4,
        WAIT_J = 4'd5,
        GET_J  = 4'd6,
        WR_I   = 4'd7,
        WR_J   = 4'd8,
        SET_F  = 4'd9,
        WAIT_F = 4'd10,
        GET_F  = 4'd11,
        WR_D   = 4'd12,
        DONE   = 4'd13
    } prga_state_t;

    // States in which the S-array swap is written back.
    function automatic logic is_s_write(input prga_state_t st);
        return (st == WR_I) || (st == WR_J);
    endfunction

    // States that present the S address of the current f lookup.
    function automatic logic is_f_read(input prga_state_t st);
        return (st == SET_F) || (st == WAIT_F) || (st == GET_F);
    endfunction

endpackage

// File: rtl/rc4_prga.sv
// RC4 pseudo-random generation stage. Walks an already key-scheduled S array
// held in an external synchronous RAM, swaps S[i]/S[j] for every message byte,
// and writes keystream ^ ciphertext into the decrypted-message RAM.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous active-low reset
//   start_sig      level start request, held until prga_finished is seen
//   prga_finished  high while parked in DONE
//   s_address      S RAM address (read data returns one cycle later)
//   s_ram_in       S RAM write data
//   s_write_enable S RAM write strobe
//   s_ram_out      S RAM read data
//   rom_address    ciphertext ROM address (byte index k)
//   rom_out        ciphertext byte
//   d_address      plaintext RAM address
//   d_ram_in       plaintext byte
//   d_write_enable plaintext RAM write strobe
module rc4_prga
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = RC4_MSG_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sig,
    output logic              prga_finished,
    output logic [BYTE_W-1:0] s_address,
    output logic [BYTE_W-1:0] s_ram_in,
    output logic              s_write_enable,
    input  logic [BYTE_W-1:0] s_ram_out,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [BYTE_W-1:0] rom_out,
    output logic [ADDR_W-1:0] d_address,
    output logic [BYTE_W-1:0] d_ram_in,
    output logic              d_write_enable
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

    prga_state_t       state;
    logic [BYTE_W-1:0] i;
    logic [BYTE_W-1:0] j;
    logic [ADDR_W-1:0] k;
    logic [BYTE_W-1:0] si;
    logic [BYTE_W-1:0] sj;
    logic [BYTE_W-1:0] f;

    // Sequencer and datapath registers. All index arithmetic is 8-bit and
    // wraps naturally; the carry out of j and si+sj is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            f     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= SET_I;
                    end
                end
                SET_I: begin
                    i     <= i + BYTE_W'(1);
                    state <= WAIT_I;
                end
                WAIT_I: state <= GET_I;
                GET_I: begin
                    si    <= s_ram_out;
                    j     <= j + s_ram_out;
                    state <= SET_J;
                end
                SET_J:  state <= WAIT_J;
                WAIT_J: state <= GET_J;
                GET_J: begin
                    sj    <= s_ram_out;
                    state <= WR_I;
                end
                WR_I:   state <= WR_J;
                WR_J:   state <= SET_F;
                SET_F:  state <= WAIT_F;
                WAIT_F: state <= GET_F;
                GET_F: begin
                    f     <= s_ram_out;
                    state <= WR_D;
                end
                WR_D: begin
                    if (k == LAST_K) begin
                        state <= DONE;
                    end else begin
                        k     <= k + ADDR_W'(1);
                        state <= SET_I;
                    end
                end
                DONE: begin
                    // Controller keeps start_sig high until it sees completion.
                    if (!start_sig) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore output decode: strobes depend on state only, addresses on state
    // plus registered indices. The address is held through the wait state so
    // the RAM read data is valid when the GET state captures it.
    always_comb begin
        prga_finished  = 1'b0;
        s_address      = '0;
        s_ram_in       = '0;
        s_write_enable = 1'b0;
        rom_address    = '0;
        d_address      = '0;
        d_ram_in       = '0;
        d_write_enable = 1'b0;

        if (state != IDLE && state != DONE) begin
            rom_address = k;
        end

        case (state)
            // i is incremented on this edge, so present the new value early.
            SET_I:          s_address = i + BYTE_W'(1);
            WAIT_I, GET_I:  s_address = i;
            SET_J, WAIT_J,
            GET_J:          s_address = j;
            WR_I: begin
                s_address = i;
                s_ram_in  = sj;
            end
            // When i == j this second write lands on the same entry and
            // leaves si there, matching a swap of an entry with itself.
            WR_J: begin
                s_address = j;
                s_ram_in  = si;
            end
            WR_D: begin
                d_address = k;
                d_ram_in  = f ^ rom_out;
            end
            DONE:    prga_finished = 1'b1;
            default: ;
        endcase

        if (is_f_read(state)) begin
            s_address = si + sj;
        end

        s_write_enable = is_s_write(state);
        d_write_enable = (state == WR_D);
    end

endmodule

// File: tb/tb_rc4_prga.sv
// Bench for rc4_prga: S RAM / ciphertext ROM models, a textbook RC4 reference
// model feeding a scoreboard of expected plaintext writes, and directed cases
// for collision, wrap, reset abort, done hold and start glitch behaviour.
module tb_rc4_prga;
    import rc4_pkg::*;

    localparam int unsigned N         = RC4_MSG_LEN;
    localparam int          RUN_EDGES = BYTE_CYCLES * N;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_sig;
    logic              prga_finished;
    logic [BYTE_W-1:0] s_address;
    logic [BYTE_W-1:0] s_ram_in;
    logic              s_write_enable;
    logic [BYTE_W-1:0] s_ram_out;
    logic [ADDR_W-1:0] rom_address;
    logic [BYTE_W-1:0] rom_out;
    logic [ADDR_W-1:0] d_address;
    logic [BYTE_W-1:0] d_ram_in;
    logic              d_write_enable;

    logic [7:0]  s_mem  [256];
    logic [7:0]  s_init [256];
    logic [7:0]  s_exp  [256];
    logic [7:0]  s_q;
    logic [7:0]  rom    [N];
    logic [7:0]  enc    [N];
    logic [7:0]  d_mem  [N];
    logic [7:0]  d_ref  [N];
    logic [7:0]  d_c    [N];
    logic [12:0] sb_q[$];
    logic [15:0] s_log[$];
    bit          log_en  = 1'b0;
    bit          load_req = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          s_wr_cnt = 0;
    int          d_wr_cnt = 0;

    rc4_prga #(.MSG_LEN(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_sig      (start_sig),
        .prga_finished  (prga_finished),
        .s_address      (s_address),
        .s_ram_in       (s_ram_in),
        .s_write_enable (s_write_enable),
        .s_ram_out      (s_ram_out),
        .rom_address    (rom_address),
        .rom_out        (rom_out),
        .d_address      (d_address),
        .d_ram_in       (d_ram_in),
        .d_write_enable (d_write_enable)
    );

    always #5 clk = ~clk;

    // Synchronous-read S RAM; bulk load happens between runs.
    always @(posedge clk) begin
        s_q <= s_mem[s_address];
        if (load_req) begin
            for (int x = 0; x < 256; x++) s_mem[x] = s_init[x];
        end else if (s_write_enable) begin
            s_mem[s_address] = s_ram_in;
        end
    end
    assign s_ram_out = s_q;
    assign rom_out   = rom[rom_address];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [12:0] e;
        if (s_write_enable) begin
            s_wr_cnt++;
            if (log_en) s_log.push_back({s_address, s_ram_in});
        end
        if (d_write_enable) begin
            d_wr_cnt++;
            d_mem[d_address] = d_ram_in;
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("d_write", 32'({d_address, d_ram_in}), 32'(e));
            end
        end
    end

    // Load memories and push the reference RC4 keystream result.
    task automatic prepare_run();
        logic [7:0] sm [256];
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) sm[x] = s_init[x];
        for (int x = 0; x < int'(N); x++) rom[x] = enc[x];
        i = 8'd0;
        j = 8'd0;
        for (int kk = 0; kk < int'(N); kk++) begin
            i = i + 8'd1;
            j = j + sm[i];
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
            t = 8'(sm[i] + sm[j]);
            d_ref[kk] = sm[t] ^ enc[kk];
            sb_q.push_back({5'(kk), d_ref[kk]});
        end
        for (int x = 0; x < 256; x++) s_exp[x] = sm[x];
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Raise start and count edges until completion; optional start glitch.
    task automatic start_run(input int pulse_at);
        int edges;
        @(negedge clk);
        start_sig = 1'b1;
        @(posedge clk);
        edges = 0;
        while (edges < 2 * RUN_EDGES) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == pulse_at)     start_sig = 1'b0;
            if (edges == pulse_at + 5) start_sig = 1'b1;
            if (prga_finished) break;
        end
        check_eq("finish_edge", 32'(edges), 32'(RUN_EDGES));
    endtask

    task automatic finish_run();
        int mism = 0;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int x = 0; x < 256; x++) if (s_mem[x] !== s_exp[x]) mism++;
        check_eq("s_final", 32'(mism), 32'd0);
        @(negedge clk);
        start_sig = 1'b0;
        @(posedge clk);
        #1 check_eq("finished_drop", 32'(prga_finished), 32'd0);
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    initial begin
        int lows, sw0, dw0, mism, r;
        logic [7:0] t;
        reset     = 1'b0;
        start_sig = 1'b0;
        for (int x = 0; x < 256; x++) s_mem[x] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_finished", 32'(prga_finished), 32'd0);
        check_eq("rst_s_we", 32'(s_write_enable), 32'd0);
        check_eq("rst_d_we", 32'(d_write_enable), 32'd0);
        check_eq("rst_s_addr", 32'(s_address), 32'd0);
        check_eq("rst_d_addr", 32'(d_address), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_address), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Identity S: first byte has i == j == 1, second byte swaps S[2]/S[3].
        identity_s();
        for (int x = 0; x < int'(N); x++) enc[x] = 8'($urandom_range(0, 255));
        enc[0] = 8'h35;
        prepare_run();
        s_log.delete();
        log_en = 1'b1;
        start_run(-100);
        log_en = 1'b0;
        check_eq("a_d0", 32'(d_mem[0]), 32'h37);
        check_eq("a_d1", 32'(d_mem[1]), 32'(8'h05 ^ enc[1]));
        check_eq("a_s_wr_n", 32'(s_log.size()), 32'(2 * N));
        if (s_log.size() >= 4) begin
            check_eq("a_wr0", 32'(s_log[0]), 32'h0101);
            check_eq("a_wr1", 32'(s_log[1]), 32'h0101);
            check_eq("a_wr2", 32'(s_log[2]), 32'h0203);
            check_eq("a_wr3", 32'(s_log[3]), 32'h0302);
        end
        finish_run();

        // S[1] = 0xFF: j wraps to 0xFF and si+sj wraps to 0xFE.
        identity_s();
        s_init[1] = 8'hFF;
        for (int x = 0; x < int'(N); x++) enc[x] = 8'($urandom_range(0, 255));
        enc[0] = 8'h00;
        prepare_run();
        start_run(-100);
        check_eq("b_d0", 32'(d_mem[0]), 32'hFE);
        finish_run();

        // Random permutation, full run, then hold start 200 cycles past done.
        identity_s();
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(0, x));
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
        for (int x = 0; x < int'(N); x++) enc[x] = 8'($urandom_range(0, 255));
        prepare_run();
        start_run(-100);
        for (int x = 0; x < int'(N); x++) d_c[x] = d_mem[x];
        sw0  = s_wr_cnt;
        dw0  = d_wr_cnt;
        lows = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (!prga_finished) lows++;
        end
        check_eq("hold_finished", 32'(lows), 32'd0);
        check_eq("hold_writes", 32'(s_wr_cnt - sw0 + d_wr_cnt - dw0), 32'd0);
        finish_run();

        // Reset at cycle 100 of a run, then a clean rerun on reloaded memories.
        prepare_run();
        @(negedge clk);
        start_sig = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset     = 1'b0;
        start_sig = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_s_we", 32'(s_write_enable), 32'd0);
        check_eq("abort_d_we", 32'(d_write_enable), 32'd0);
        check_eq("abort_finished", 32'(prga_finished), 32'd0);
        check_eq("abort_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b1;
        sb_q.delete();
        sw0 = s_wr_cnt;
        dw0 = d_wr_cnt;
        repeat (20) @(posedge clk);
        #1 check_eq("no_resume", 32'(s_wr_cnt - sw0 + d_wr_cnt - dw0), 32'd0);
        prepare_run();
        start_run(-100);
        mism = 0;
        for (int x = 0; x < int'(N); x++) if (d_mem[x] !== d_c[x]) mism++;
        check_eq("rerun_d", 32'(mism), 32'd0);
        finish_run();

        // Start dropped for 5 cycles mid-run must not disturb the run.
        prepare_run();
        dw0 = d_wr_cnt;
        start_run(150);
        mism = 0;
        for (int x = 0; x < int'(N); x++) if (d_mem[x] !== d_c[x]) mism++;
        check_eq("glitch_d", 32'(mism), 32'd0);
        check_eq("glitch_d_n", 32'(d_wr_cnt - dw0), 32'(N));
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_prga.md
RC4_PRGA -- requirements
Module: rc4_prga

Interface
REQ-001 SHALL declare parameter MSG_LEN, default 32, number of message bytes decrypted per run.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous active-low reset (0 = reset).
REQ-004 SHALL have port start_sig  in  1  level start request; held high by the controller until prga_finished is seen.
REQ-005 SHALL have port prga_finished  out  1  run complete; high in DONE only.
REQ-006 SHALL have port s_address  out  8  address into the S-array RAM.
REQ-007 SHALL have port s_ram_in  out  8  write data to the S-array RAM.
REQ-008 SHALL have port s_write_enable  out  1  S-array RAM write strobe.
REQ-009 SHALL have port s_ram_out  in  8  S-array RAM read data, valid one cycle after s_address is presented.
REQ-010 SHALL have port rom_address  out  5  encrypted-message ROM address (equal to byte index k).
REQ-011 SHALL have port rom_out  in  8  encrypted byte, stable while rom_address is held.
REQ-012 SHALL have port d_address  out  5  decrypted-message RAM address.
REQ-013 SHALL have port d_ram_in  out  8  decrypted byte.
REQ-014 SHALL have port d_write_enable  out  1  decrypted RAM write strobe.

Function
REQ-015 SHALL consume the S array already permuted by the key-scheduling stage and perform the RC4 PRGA with i, j, k reset to 0 at each run start.
REQ-016 SHALL implement FSM states IDLE, SET_I, WAIT_I, GET_I, SET_J, WAIT_J, GET_J, WR_I, WR_J, SET_F, WAIT_F, GET_F, WR_D, DONE.
REQ-017 SHALL go IDLE->SET_I when start_sig=1 is sampled; otherwise stay in IDLE.
REQ-018 SHALL per byte: SET_I i<=i+1 and drive s_address=i+1; GET_I si<=s_ram_out, j<=j+s_ram_out; SET_J drive s_address=j; GET_J sj<=s_ram_out; WR_I write S[i]=sj; WR_J write S[j]=si; SET_F drive s_address=si+sj; GET_F f<=s_ram_out; WR_D write d_ram_in=f^rom_out at d_address=k.
REQ-019 SHALL hold rom_address=k for the whole byte iteration.
REQ-020 SHALL in WR_D go to DONE if k==MSG_LEN-1, else k<=k+1 and go to SET_I.
REQ-021 SHALL take exactly 12 cycles per byte; prga_finished rises on the 12*MSG_LEN-th edge (384 for default) after the edge that samples start_sig high.
REQ-022 SHALL perform all i, j and si+sj arithmetic modulo 256 (8-bit wrap, carry discarded).
REQ-023 SHALL, when i==j, write WR_I then WR_J to the same address; the final value is si.
REQ-024 SHALL decode s_write_enable (WR_I, WR_J only) and d_write_enable (WR_D only) from state alone, never from inputs.
REQ-025 SHALL ignore start_sig changes between SET_I and WR_D; the run always completes.
REQ-026 SHALL stay in DONE while start_sig=1, issuing no writes; go to IDLE on the first edge sampling start_sig=0.
REQ-027 SHALL drive all write enables 0 and addresses 0 in IDLE and DONE.

Reset
REQ-028 SHALL, on any edge with reset=0, enter IDLE, clear i, j, k, si, sj, f and drop prga_finished and all write enables to 0 from the next cycle, including mid-run.
REQ-029 SHALL require start_sig sampled high after reset release to start a new run; no run resumption.

Structure
REQ-030 SHALL place the state enum, MSG_LEN default, and 8-bit and 5-bit width constants in shared package rc4_pkg, also used by the key-scheduling block.
REQ-031 SHALL be a single module with no sub-modules; one sequential FSM/datapath process plus Moore output decode.

Verification
REQ-032 SHALL cover identity S (S[x]=x), enc[0]=0x35: byte 0 i=j=1 collision, S unchanged, d[0]=0x37; byte 1 writes S[2]=3, S[3]=2, d[1]=0x05^enc[1].
REQ-033 SHALL cover identity S except S[1]=0xFF, enc[0]=0x00: j=0xFF, si+sj wraps to 0xFE, d[0]=0xFE.
REQ-034 SHALL cover a full 32-byte run against a reference model, checking all d bytes, final S, and prga_finished exactly at edge 384.
REQ-035 SHALL cover reset=0 at cycle 100 of a run: write enables 0 next cycle, FSM IDLE; rerun on reloaded memories matches a clean run.
REQ-036 SHALL cover start_sig held 200 cycles past done: prga_finished stays 1, zero writes; start_sig=0 -> prga_finished 0 next edge.
REQ-037 SHALL cover start_sig pulsed 0 for 5 cycles mid-run: run completes unchanged, outputs identical to REQ-034.
